ripemd160_combine: RTL
======================

RIPEMD160_COMBINE -- requirements
Module: ripemd160_combine

Interface
REQ-001 SHALL have parameter BSWAP, default 1: when 1, each 32-bit output word is byte-reversed into conventional digest byte order.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port i_valid_l, input, 1: left-line result valid, one-cycle pulse.
REQ-005 SHALL have port i_left, input, 160: left-line result {A1,B1,C1,D1,E1}, A1 in [159:128].
REQ-006 SHALL have port i_valid_r, input, 1: right-line result valid, one-cycle pulse.
REQ-007 SHALL have port i_right, input, 160: right-line result {A2,B2,C2,D2,E2}, A2 in [159:128].
REQ-008 SHALL have port i_last, input, 1: final block of message, sampled with i_valid_l.
REQ-009 SHALL have port o_ready, input, 1: downstream accepts o_digest.
REQ-010 SHALL have port o_valid, output, 1: o_digest valid, held until accepted.
REQ-011 SHALL have port o_digest, output, 160: {h0,h1,h2,h3,h4}, h0 in [159:128].
REQ-012 SHALL have port o_chain, output, 160: chaining value {h0..h4} that the line stages load as initial state.
REQ-013 SHALL have port o_busy, output, 1: high in any state other than IDLE.
REQ-014 SHALL have port o_err, output, 1: sticky protocol-error flag.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, SUM, OUT.
REQ-016 IDLE: a pulse on either valid SHALL capture that side; one side captured -> WAIT; both sides in the same cycle -> SUM.
REQ-017 WAIT: a pulse from the missing side SHALL capture it and go to SUM; a repeat pulse from the captured side SHALL set o_err, be ignored, and leave the state unchanged.
REQ-018 WAIT with both pulses in the same cycle: SHALL capture the missing side, set o_err for the repeat, and go to SUM.
REQ-019 SUM: SHALL compute in one cycle, all additions mod 2^32: h0'=H1+C1+D2; h1'=H2+D1+E2; h2'=H3+E1+A2; h3'=H4+A1+B2; h4'=H0+B1+C2. H0..H4 are the current chaining words.
REQ-020 SUM: SHALL register the results into the digest register and go to OUT.
REQ-021 OUT: o_valid SHALL be 1; o_valid&&o_ready SHALL go to IDLE; o_digest SHALL be stable while o_valid&&!o_ready.
REQ-022 Latency: the edge that captures the second side, plus 2 edges, to o_valid high (capture edge -> SUM, next edge -> OUT).
REQ-023 Any i_valid_l or i_valid_r in SUM or OUT SHALL set o_err and be ignored.
REQ-024 o_err SHALL clear only on reset.

Reset
REQ-025 On rst, SHALL asynchronously set state IDLE, o_valid 0, o_err 0, captured registers and digest register 0, chaining register H0..H4 = 67452301, efcdab89, 98badcfe, 10325476, c3d2e1f0.
REQ-026 Reset mid-operation SHALL discard all partial results; the first valid after reset deasserts SHALL start a fresh capture.

Configuration
REQ-027 Macro RIPEMD160_CHAIN_EN defined: the chaining register SHALL load h0'..h4' in SUM. After the OUT handshake of a block whose captured i_last=1, it SHALL reload the initial values. o_chain SHALL equal the chaining register.
REQ-028 RIPEMD160_CHAIN_EN undefined: H SHALL be the constant initial values; i_last SHALL be ignored; o_chain SHALL be tied to the initial constants.

Structure
REQ-029 A shared package ripemd160_pkg SHALL hold the five initial-value constants and the FSM state typedef.
REQ-030 SHALL contain one sub-module, ripemd160_bswap32: combinational 32-bit byte reversal, instantiated five times under BSWAP.

Verification
REQ-031 i_left=0, i_right=0, both pulsed together, BSWAP=0 -> o_digest = efcdab89_98badcfe_10325476_c3d2e1f0_67452301 two edges later.
REQ-032 Same stimulus, BSWAP=1 -> o_digest = 89abcdef_fedcba98_76543210_f0e1d2c3_01234567.
REQ-033 Golden-model line outputs for the padded empty message, right 5 cycles after left, BSWAP=1 -> o_digest = 9c1185a5c5e9fc54612808977ee8f548b2258d31.
REQ-034 Hold o_ready=0 for 10 cycles in OUT -> o_valid and o_digest stable; then o_ready=1 -> IDLE, o_busy=0 next cycle.
REQ-035 Double i_valid_l in WAIT, and any valid in OUT -> o_err=1 and persisting; the digest is unaffected.
REQ-036 RIPEMD160_CHAIN_EN defined: two blocks, first i_last=0 -> o_chain equals the first digest (pre-swap); second i_last=1 -> o_chain returns to 67452301... after the handshake. Assert rst during WAIT -> o_busy=0 and o_valid=0 immediately.

Source files
------------

// File: rtl/ripemd160_pkg.sv
// rtl/ripemd160_pkg.sv - RIPEMD-160 initial chaining words and combine FSM state type
package ripemd160_pkg;

    localparam logic [31:0] H0_INIT = 32'h67452301;
    localparam logic [31:0] H1_INIT = 32'hefcdab89;
    localparam logic [31:0] H2_INIT = 32'h98badcfe;
    localparam logic [31:0] H3_INIT = 32'h10325476;
    localparam logic [31:0] H4_INIT = 32'hc3d2e1f0;

    localparam logic [159:0] CHAIN_INIT = {H0_INIT, H1_INIT, H2_INIT, H3_INIT, H4_INIT};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SUM  = 2'd2,
        OUT  = 2'd3
    } state_t;

endpackage

// File: rtl/ripemd160_bswap32.sv
// rtl/ripemd160_bswap32.sv - combinational 32-bit byte reversal
module ripemd160_bswap32 (
    input  logic [31:0] word,
    output logic [31:0] swapped
);

    assign swapped = {word[7:0], word[15:8], word[23:16], word[31:24]};

endmodule

// File: rtl/ripemd160_combine.sv
// rtl/ripemd160_combine.sv - joins left/right line results into h0..h4 (optional chaining: RIPEMD160_CHAIN_EN)
module ripemd160_combine
    import ripemd160_pkg::*;
#(
    parameter int BSWAP = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid_l,
    input  logic [159:0] i_left,
    input  logic         i_valid_r,
    input  logic [159:0] i_right,
    input  logic         i_last,
    input  logic         o_ready,
    output logic         o_valid,
    output logic [159:0] o_digest,
    output logic [159:0] o_chain,
    output logic         o_busy,
    output logic         o_err
);

    state_t        state;
    logic          have_l;      // in WAIT: 1 when the left side is the one already captured
    logic [159:0]  left_q;
    logic [159:0]  right_q;
    logic [159:0]  digest_q;    // pre-swap h0'..h4'
    logic [159:0]  chain_w;
    logic [159:0]  sum_w;
    logic          take_l;
    logic          take_r;
    logic          err_evt;

`ifdef RIPEMD160_CHAIN_EN
    logic [159:0]  chain_q;
    logic          last_q;

    assign chain_w = chain_q;
`else
    logic          unused_last;

    assign chain_w     = CHAIN_INIT;
    assign unused_last = i_last;
`endif

    // A pulse is accepted only in IDLE or as the missing side in WAIT; any other pulse is a protocol error
    always_comb begin
        take_l  = i_valid_l && ((state == IDLE) || ((state == WAIT) && !have_l));
        take_r  = i_valid_r && ((state == IDLE) || ((state == WAIT) && have_l));
        err_evt = (i_valid_l && !take_l) || (i_valid_r && !take_r);
    end

    // Final addition, rotated one word across lines: h0'=H1+C1+D2 ... h4'=H0+B1+C2
    always_comb begin
        sum_w = {chain_w[127:96] + left_q[95:64]   + right_q[63:32],
                 chain_w[95:64]  + left_q[63:32]   + right_q[31:0],
                 chain_w[63:32]  + left_q[31:0]    + right_q[159:128],
                 chain_w[31:0]   + left_q[159:128] + right_q[127:96],
                 chain_w[159:128] + left_q[127:96] + right_q[95:64]};
    end

    // Capture/sum/output sequencing with sticky error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            have_l   <= 1'b0;
            left_q   <= '0;
            right_q  <= '0;
            digest_q <= '0;
            o_valid  <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            if (err_evt) begin
                o_err <= 1'b1;
            end
            if (take_l) begin
                left_q <= i_left;
            end
            if (take_r) begin
                right_q <= i_right;
            end
            case (state)
                IDLE: begin
                    have_l <= take_l;
                    if (take_l && take_r) begin
                        state <= SUM;
                    end else if (take_l || take_r) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (take_l || take_r) begin
                        state <= SUM;
                    end
                end
                SUM: begin
                    digest_q <= sum_w;
                    o_valid  <= 1'b1;
                    state    <= OUT;
                end
                OUT: begin
                    if (o_ready) begin
                        o_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RIPEMD160_CHAIN_EN
    // Chaining value follows each block and returns to the IV once the last block is handed off
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q <= CHAIN_INIT;
            last_q  <= 1'b0;
        end else begin
            if (take_l) begin
                last_q <= i_last;
            end
            if (state == SUM) begin
                chain_q <= sum_w;
            end else if ((state == OUT) && o_ready && last_q) begin
                chain_q <= CHAIN_INIT;
            end
        end
    end
`endif

    assign o_chain = chain_w;
    assign o_busy  = (state != IDLE);

    genvar g;
    generate
        for (g = 0; g < 5; g++) begin : g_word
            if (BSWAP != 0) begin : g_swap
                ripemd160_bswap32 u_bswap (
                    .word    (digest_q[g*32 +: 32]),
                    .swapped (o_digest[g*32 +: 32])
                );
            end else begin : g_pass
                assign o_digest[g*32 +: 32] = digest_q[g*32 +: 32];
            end
        end
    endgenerate

endmodule
